fft_butterfly: RTL and testbench

Pipelined radix-2 decimation-in-time butterfly coprocessor for the FFT/IFFT extension of the 5-stage RISC-V core. The core's EX stage issues one complex butterfly per cycle: operands come from the forwarded rs1/rs2 values, and the twiddle index and direction come from the decoded instruction. Three cycles later the block returns X = (A + B·W)/2 and Y = (A − B·W)/2 to the EX/MEM result mux, tagged with the destination register. Scaling by 1/2 per stage prevents growth across log2(N) passes.

---
 rtl/fft_pkg.sv | 43 ++++
 rtl/fft_butterfly_if.sv | 30 +++
 rtl/fft_twiddle_rom.sv | 33 +++
 rtl/fft_butterfly.sv | 129 ++++++++++++
 tb/tb_fft_butterfly.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared Q1.15 constants, complex packing helpers and saturation for the FFT butterfly.
// Combinational helpers only; no state, no latency, no flow control.
package fft_pkg;

  localparam int N  = 32;
  localparam int DW = 16;
  localparam int CW = 2 * DW;

  localparam logic signed [DW-1:0] ONE       = 16'sh7FFF;
  localparam logic signed [DW-1:0] MINUS_ONE = 16'sh8000;
  // Wide enough for BrWr - BiWi + RND without overflow
  localparam logic signed [33:0]   RND       = 34'sh0_0000_4000;
  localparam logic signed [33:0]   SAT_MAX   = 34'sh0_0000_7FFF;
  localparam logic signed [33:0]   SAT_MIN   = -34'sh0_0000_8000;

  typedef logic signed [DW-1:0] comp_t;
  typedef logic [CW-1:0]        cplx_t;

  function automatic comp_t cplx_re(input cplx_t c);
    return c[CW-1:DW];
  endfunction

  function automatic comp_t cplx_im(input cplx_t c);
    return c[DW-1:0];
  endfunction

  function automatic cplx_t cplx_pack(input comp_t r, input comp_t i);
    return {r, i};
  endfunction

  function automatic comp_t sat_dw(input logic signed [33:0] v);
    comp_t r;
    if (v > SAT_MAX)      r = ONE;
    else if (v < SAT_MIN) r = MINUS_ONE;
    else                  r = v[DW-1:0];
    return r;
  endfunction

  function automatic comp_t neg_sat(input comp_t v);
    return (v == MINUS_ONE) ? ONE : -v;
  endfunction

endpackage

// File: rtl/fft_butterfly_if.sv
// Issue/result bundle between the core's EX stage and the butterfly coprocessor.
// master = core side, slave = butterfly side; no backpressure signals exist.
interface fft_butterfly_if;
  import fft_pkg::*;

  logic          in_valid;
  logic [CW-1:0] in_a;
  logic [CW-1:0] in_b;
  logic [3:0]    in_k;
  logic          in_inv;
  logic [4:0]    in_tag;
  logic          hold;
  logic          flush;
  logic          out_valid;
  logic [CW-1:0] out_x;
  logic [CW-1:0] out_y;
  logic [4:0]    out_tag;
  logic          busy;

  modport master (
    output in_valid, in_a, in_b, in_k, in_inv, in_tag, hold, flush,
    input  out_valid, out_x, out_y, out_tag, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_k, in_inv, in_tag, hold, flush,
    output out_valid, out_x, out_y, out_tag, busy
  );

endinterface

// File: rtl/fft_twiddle_rom.sv
// N=32 twiddle table W_k = cos(2pi k/N) - j sin(2pi k/N), Q1.15 rounded, +1.0 clamped.
// Purely combinational, zero latency, no flow control.
module fft_twiddle_rom
  import fft_pkg::*;
(
  input  logic [3:0] k_i,
  output cplx_t      w_o
);

  always_comb begin
    w_o = '0;
    case (k_i)
      4'd0:  w_o = {16'h7FFF, 16'h0000};
      4'd1:  w_o = {16'h7D8A, 16'hE707};
      4'd2:  w_o = {16'h7642, 16'hCF04};
      4'd3:  w_o = {16'h6A6E, 16'hB8E3};
      4'd4:  w_o = {16'h5A82, 16'hA57E};
      4'd5:  w_o = {16'h471D, 16'h9592};
      4'd6:  w_o = {16'h30FC, 16'h89BE};
      4'd7:  w_o = {16'h18F9, 16'h8276};
      4'd8:  w_o = {16'h0000, 16'h8000};
      4'd9:  w_o = {16'hE707, 16'h8276};
      4'd10: w_o = {16'hCF04, 16'h89BE};
      4'd11: w_o = {16'hB8E3, 16'h9592};
      4'd12: w_o = {16'hA57E, 16'hA57E};
      4'd13: w_o = {16'h9592, 16'hB8E3};
      4'd14: w_o = {16'h89BE, 16'hCF04};
      4'd15: w_o = {16'h8276, 16'hE707};
      default: w_o = '0;
    endcase
  end

endmodule

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly X,Y = (A +/- B*W)/2 in Q1.15, three register stages, latency 3.
// No backpressure: hold freezes every stage, flush clears every valid bit.
module fft_butterfly #(
  parameter int N  = 32,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  fft_butterfly_if.slave bus
);
  import fft_pkg::*;

  localparam int PW = 2 * DW;

  logic [3:0]            k_idx;
  cplx_t                 w_rom;
  logic signed [DW-1:0]  w_re, w_im, b_re, b_im;

  // Index wraps modulo the table size so other N still address valid entries
  assign k_idx = 4'(int'(bus.in_k) % (N / 2));

  fft_twiddle_rom u_rom (
    .k_i (k_idx),
    .w_o (w_rom)
  );

  assign w_re = cplx_re(w_rom);
  assign w_im = bus.in_inv ? neg_sat(cplx_im(w_rom)) : cplx_im(w_rom);
  assign b_re = cplx_re(bus.in_b);
  assign b_im = cplx_im(bus.in_b);

  // S1: products
  logic                 v1_q;
  logic [4:0]           tag1_q;
  logic [PW-1:0]        a1_q;
  logic signed [PW-1:0] rr_q, ii_q, ri_q, ir_q;
  logic signed [PW-1:0] rr_d, ii_d, ri_d, ir_d;

  // S2: rounded, saturated B*W
  logic                 v2_q;
  logic [4:0]           tag2_q;
  logic [PW-1:0]        a2_q;
  logic signed [DW-1:0] pr_q, pi_q;
  logic signed [DW-1:0] pr_d, pi_d;
  logic signed [33:0]   sum_re, sum_im;

  // S3: halved sum/difference
  logic                 v3_q;
  logic [4:0]           tag3_q;
  logic [PW-1:0]        x_q, y_q;
  logic [PW-1:0]        x_d, y_d;
  logic [DW:0]          xr_s, xi_s, yr_s, yi_s;
  logic signed [DW-1:0] a2_re, a2_im;

  always_comb begin
    rr_d = b_re * w_re;
    ii_d = b_im * w_im;
    ri_d = b_re * w_im;
    ir_d = b_im * w_re;
  end

  always_comb begin
    sum_re = $signed({{2{rr_q[PW-1]}}, rr_q}) - $signed({{2{ii_q[PW-1]}}, ii_q}) + RND;
    sum_im = $signed({{2{ri_q[PW-1]}}, ri_q}) + $signed({{2{ir_q[PW-1]}}, ir_q}) + RND;
    pr_d   = sat_dw(sum_re >>> 15);
    pi_d   = sat_dw(sum_im >>> 15);
  end

  // 17-bit sums of two Q1.15 values always fit in 16 bits after halving
  always_comb begin
    a2_re = cplx_re(a2_q);
    a2_im = cplx_im(a2_q);
    xr_s  = {a2_re[DW-1], a2_re} + {pr_q[DW-1], pr_q};
    xi_s  = {a2_im[DW-1], a2_im} + {pi_q[DW-1], pi_q};
    yr_s  = {a2_re[DW-1], a2_re} - {pr_q[DW-1], pr_q};
    yi_s  = {a2_im[DW-1], a2_im} - {pi_q[DW-1], pi_q};
    x_d   = cplx_pack(xr_s[DW:1], xi_s[DW:1]);
    y_d   = cplx_pack(yr_s[DW:1], yi_s[DW:1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      tag1_q <= '0;
      a1_q   <= '0;
      rr_q   <= '0;
      ii_q   <= '0;
      ri_q   <= '0;
      ir_q   <= '0;
      v2_q   <= 1'b0;
      tag2_q <= '0;
      a2_q   <= '0;
      pr_q   <= '0;
      pi_q   <= '0;
      v3_q   <= 1'b0;
      tag3_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else if (bus.flush) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (!bus.hold) begin
      v1_q   <= bus.in_valid;
      tag1_q <= bus.in_tag;
      a1_q   <= bus.in_a;
      rr_q   <= rr_d;
      ii_q   <= ii_d;
      ri_q   <= ri_d;
      ir_q   <= ir_d;
      v2_q   <= v1_q;
      tag2_q <= tag1_q;
      a2_q   <= a1_q;
      pr_q   <= pr_d;
      pi_q   <= pi_d;
      v3_q   <= v2_q;
      tag3_q <= tag2_q;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.out_x     = x_q;
  assign bus.out_y     = y_q;
  assign bus.out_tag   = tag3_q;
  assign bus.busy      = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_fft_butterfly.sv
// Randomized bench for fft_butterfly against a real-arithmetic reference and a pending-op queue.
module tb_fft_butterfly;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_butterfly_if bus();

  fft_butterfly dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          rem;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  tag;
  } op_t;

  op_t q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int q15(input real v);
    real s;
    int  r;
    s = v * 32768.0;
    if (s >= 0.0) r = $rtoi($floor(s + 0.5));
    else          r = -$rtoi($floor(-s + 0.5));
    if (r > 32767) r = 32767;
    return r;
  endfunction

  function automatic void twiddle(input int k, input bit inv, output longint wr, output longint wi);
    real th;
    th = 2.0 * 3.141592653589793 * real'(k % 16) / 32.0;
    wr = longint'(q15($cos(th)));
    wi = longint'(q15(-$sin(th)));
    if (inv) wi = (wi == -32768) ? 32767 : -wi;
  endfunction

  function automatic longint sx16(input logic [15:0] v);
    logic signed [15:0] t;
    t = v;
    return longint'(t);
  endfunction

  function automatic longint satq(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Returns {X, Y}
  function automatic logic [63:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                       input int k, input bit inv);
    longint ar, ai, br, bi, wr, wi, pr, pi, xr, xi, yr, yi;
    ar = sx16(a[31:16]); ai = sx16(a[15:0]);
    br = sx16(b[31:16]); bi = sx16(b[15:0]);
    twiddle(k, inv, wr, wi);
    pr = satq((br * wr - bi * wi + 16384) >>> 15);
    pi = satq((br * wi + bi * wr + 16384) >>> 15);
    xr = (ar + pr) >>> 1; xi = (ai + pi) >>> 1;
    yr = (ar - pr) >>> 1; yi = (ai - pi) >>> 1;
    return {xr[15:0], xi[15:0], yr[15:0], yi[15:0]};
  endfunction

  // Reference: each accepted op needs two more advancing edges to reach the output
  initial begin
    op_t o;
    forever begin
      @(posedge clk or posedge rst);
      if (rst || bus.flush) begin
        q.delete();
      end else if (!bus.hold) begin
        foreach (q[i]) q[i].rem = q[i].rem - 1;
        if (q.size() > 0 && q[0].rem < 0) void'(q.pop_front());
        if (bus.in_valid) begin
          o.rem = 2;
          {o.x, o.y} = bfly(bus.in_a, bus.in_b, int'(bus.in_k), bus.in_inv);
          o.tag = bus.in_tag;
          q.push_back(o);
        end
      end
    end
  end

  initial begin
    bit ev, eb;
    forever begin
      @(negedge clk);
      ev = (q.size() > 0) && (q[0].rem == 0);
      eb = (q.size() > 0);
      check("out_valid", 32'(bus.out_valid), 32'(ev));
      check("busy", 32'(bus.busy), 32'(eb));
      if (rst) begin
        check("rst_out_x", bus.out_x, 32'h0);
        check("rst_out_y", bus.out_y, 32'h0);
        check("rst_out_tag", 32'(bus.out_tag), 32'h0);
      end else if (ev) begin
        check("out_x", bus.out_x, q[0].x);
        check("out_y", bus.out_y, q[0].y);
        check("out_tag", 32'(bus.out_tag), 32'(q[0].tag));
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] k, input bit inv, input logic [4:0] tag,
                       input bit h, input bit f);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_k     = k;
    bus.in_inv   = inv;
    bus.in_tag   = tag;
    bus.hold     = h;
    bus.flush    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [15:0] rnd_comp();
    case ($urandom_range(0, 3))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [63:0] r;
    longint      wr, wi;
    logic [15:0] wr16, wi16;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_k = '0;
    bus.in_inv = 1'b0; bus.in_tag = '0; bus.hold = 1'b0; bus.flush = 1'b0;

    twiddle(0, 1'b0, wr, wi); wr16 = wr[15:0]; wi16 = wi[15:0];
    check("model_tw_k0", {wr16, wi16}, 32'h7FFF_0000);
    twiddle(4, 1'b0, wr, wi); wr16 = wr[15:0]; wi16 = wi[15:0];
    check("model_tw_k4", {wr16, wi16}, 32'h5A82_A57E);
    twiddle(8, 1'b1, wr, wi); wr16 = wr[15:0]; wi16 = wi[15:0];
    check("model_tw_k8_inv", {wr16, wi16}, 32'h0000_7FFF);
    r = bfly(32'h4000_0000, 32'h2000_0000, 0, 1'b0);
    check("model_k0_x", r[63:32], 32'h3000_0000);
    check("model_k0_y", r[31:0],  32'h1000_0000);
    r = bfly(32'h0, 32'h2000_0000, 8, 1'b0);
    check("model_k8_x", r[63:32], 32'h0000_F000);
    check("model_k8_y", r[31:0],  32'h0000_1000);
    r = bfly(32'h0, 32'h2000_0000, 8, 1'b1);
    check("model_k8inv_x", r[63:32], 32'h0000_1000);
    check("model_k8inv_y", r[31:0],  32'h0000_F000);
    r = bfly(32'h0, 32'h8000_0000, 8, 1'b0);
    check("model_sat_x", r[63:32], 32'h0000_3FFF);
    check("model_sat_y", r[31:0],  32'h0000_C000);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    drive(1'b1, 32'h4000_0000, 32'h2000_0000, 4'd0, 1'b0, 5'd1, 1'b0, 1'b0);
    idle(4);
    drive(1'b1, 32'h0, 32'h2000_0000, 4'd8, 1'b0, 5'd2, 1'b0, 1'b0);
    drive(1'b1, 32'h0, 32'h2000_0000, 4'd8, 1'b1, 5'd3, 1'b0, 1'b0);
    drive(1'b1, 32'h0, 32'h8000_0000, 4'd8, 1'b0, 5'd4, 1'b0, 1'b0);
    idle(5);

    // Streaming with a two-cycle stall after the second issue
    drive(1'b1, 32'h1234_5678, 32'h7FFF_8000, 4'd3,  1'b0, 5'd1, 1'b0, 1'b0);
    drive(1'b1, 32'h8000_7FFF, 32'h4000_C000, 4'd12, 1'b1, 5'd2, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    drive(1'b1, 32'hFFFF_0001, 32'h0101_F0F0, 4'd5,  1'b0, 5'd3, 1'b0, 1'b0);
    drive(1'b1, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 4'd15, 1'b1, 5'd4, 1'b0, 1'b0);
    idle(6);

    // Flush with three ops in flight and a same-cycle issue
    drive(1'b1, 32'h1111_2222, 32'h3333_4444, 4'd1, 1'b0, 5'd10, 1'b0, 1'b0);
    drive(1'b1, 32'h5555_6666, 32'h7777_8888, 4'd2, 1'b0, 5'd11, 1'b0, 1'b0);
    drive(1'b1, 32'h9999_AAAA, 32'hBBBB_CCCC, 4'd6, 1'b1, 5'd12, 1'b0, 1'b0);
    drive(1'b1, 32'hDDDD_EEEE, 32'hFFFF_0000, 4'd7, 1'b0, 5'd13, 1'b0, 1'b1);
    idle(1);
    drive(1'b1, 32'h2000_2000, 32'h2000_E000, 4'd9, 1'b0, 5'd14, 1'b0, 1'b0);
    idle(4);

    // Flush and hold together
    drive(1'b1, 32'h0100_0200, 32'h0300_0400, 4'd10, 1'b0, 5'd15, 1'b0, 1'b0);
    drive(1'b1, 32'h0500_0600, 32'h0700_0800, 4'd11, 1'b0, 5'd16, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    idle(4);

    // Asynchronous reset with ops in flight
    drive(1'b1, 32'h4000_0000, 32'h2000_0000, 4'd0, 1'b0, 5'd7, 1'b0, 1'b0);
    drive(1'b1, 32'h0,         32'h2000_0000, 4'd8, 1'b0, 5'd8, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'h0);
    check("async_rst_busy", 32'(bus.busy), 32'h0);
    check("async_rst_x", bus.out_x, 32'h0);
    check("async_rst_y", bus.out_y, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 6,
            {rnd_comp(), rnd_comp()}, {rnd_comp(), rnd_comp()},
            4'($urandom), 1'($urandom), 5'($urandom),
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4);
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
